// File: rtl/data_memory_interface.sv
// data_memory_interface: load/store unit running one word-aligned req/ack bus transaction per access
module data_memory_interface (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_Read_i,
  input  logic        Mem_Write_i,
  input  logic [2:0]  Funct3_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Write_Data_i,
  output logic [31:0] Read_Data_o,
  output logic        Stall_o,
  output logic        Fault_o,
  output logic        Bus_Req_o,
  output logic        Bus_We_o,
  output logic [31:0] Bus_Addr_o,
  output logic [3:0]  Bus_Be_o,
  output logic [31:0] Bus_Wdata_o,
  input  logic [31:0] Bus_Rdata_i,
  input  logic        Bus_Ack_i
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [31:0] r_rdata;
  logic        w_any;
  logic        w_f3_ok;
  logic        w_align_ok;
  logic        w_legal;
  logic        w_idle;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [31:0] w_rdata;
  assign w_idle     = r_state == S_IDLE;
  assign w_any      = Mem_Read_i | Mem_Write_i;
  assign w_f3_ok    = Mem_Read_i ? (Funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                                 : (Funct3_i inside {3'b000, 3'b001, 3'b010});
  assign w_align_ok = Funct3_i[1:0] == 2'b01 ? ~Address_i[0] :
                      Funct3_i[1:0] == 2'b10 ? Address_i[1:0] == 2'b00 : 1'b1;
  assign w_legal    = (Mem_Read_i ^ Mem_Write_i) & w_f3_ok & w_align_ok;
  assign w_be       = Funct3_i[1:0] == 2'b00 ? 4'b0001 << Address_i[1:0] :
                      Funct3_i[1:0] == 2'b01 ? 4'b0011 << Address_i[1:0] : 4'b1111;
  assign w_wdata    = Funct3_i[1:0] == 2'b00 ? {4{Write_Data_i[7:0]}} :
                      Funct3_i[1:0] == 2'b01 ? {2{Write_Data_i[15:0]}} : Write_Data_i;
  assign w_shift    = Bus_Rdata_i >> {r_off, 3'b000};
  assign w_rdata    = r_f3 == 3'b000 ? {{24{w_shift[7]}}, w_shift[7:0]} :
                      r_f3 == 3'b001 ? {{16{w_shift[15]}}, w_shift[15:0]} :
                      r_f3 == 3'b100 ? {24'b0, w_shift[7:0]} :
                      r_f3 == 3'b101 ? {16'b0, w_shift[15:0]} : w_shift;
  // Gated by reset so the held request cannot re-raise Stall while reset is low
  assign Stall_o     = reset & ((w_idle & w_legal) | (r_state == S_BUS));
  assign Fault_o     = reset & w_idle & w_any & ~w_legal;
  assign Bus_Req_o   = r_state == S_BUS;
  assign Bus_We_o    = r_we;
  assign Bus_Addr_o  = r_addr;
  assign Bus_Be_o    = r_be;
  assign Bus_Wdata_o = r_wdata;
  assign Read_Data_o = r_rdata;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_f3    <= '0;
      r_off   <= '0;
      r_rdata <= '0;
    end else if (w_idle && w_legal) begin
      r_state <= S_BUS;
      r_addr  <= {Address_i[31:2], 2'b00};
      r_we    <= Mem_Write_i;
      r_be    <= w_be;
      r_wdata <= w_wdata;
      r_f3    <= Funct3_i;
      r_off   <= Address_i[1:0];
    end else if (r_state == S_BUS && Bus_Ack_i) begin
      r_state <= S_DONE;
      if (!r_we) r_rdata <= w_rdata;
    end else if (r_state == S_DONE) begin
      r_state <= S_IDLE;
    end
endmodule

// File: tb/tb_data_memory_interface.sv
// tb_data_memory_interface: directed checks of loads, stores, faults, wait states and reset
module tb_data_memory_interface;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Mem_Read_i = 1'b0;
  logic        Mem_Write_i = 1'b0;
  logic [2:0]  Funct3_i = '0;
  logic [31:0] Address_i = '0;
  logic [31:0] Write_Data_i = '0;
  logic [31:0] Read_Data_o;
  logic        Stall_o;
  logic        Fault_o;
  logic        Bus_Req_o;
  logic        Bus_We_o;
  logic [31:0] Bus_Addr_o;
  logic [3:0]  Bus_Be_o;
  logic [31:0] Bus_Wdata_o;
  logic [31:0] Bus_Rdata_i = '0;
  logic        Bus_Ack_i = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  data_memory_interface dut (
    .clk(clk), .reset(reset), .Mem_Read_i(Mem_Read_i), .Mem_Write_i(Mem_Write_i),
    .Funct3_i(Funct3_i), .Address_i(Address_i), .Write_Data_i(Write_Data_i),
    .Read_Data_o(Read_Data_o), .Stall_o(Stall_o), .Fault_o(Fault_o),
    .Bus_Req_o(Bus_Req_o), .Bus_We_o(Bus_We_o), .Bus_Addr_o(Bus_Addr_o),
    .Bus_Be_o(Bus_Be_o), .Bus_Wdata_o(Bus_Wdata_o), .Bus_Rdata_i(Bus_Rdata_i),
    .Bus_Ack_i(Bus_Ack_i)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Full access: drive at a negedge, ack after 'waits' idle BUS cycles, end in DONE with Mem_* still held
  task automatic op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                    input int waits, input logic [31:0] e_addr, input logic [3:0] e_be,
                    input logic [31:0] e_wd, input logic [31:0] e_rd);
    int sc;
    @(negedge clk);
    Mem_Read_i = rd; Mem_Write_i = wr; Funct3_i = f3; Address_i = addr; Write_Data_i = wd;
    #1;
    sc = Stall_o ? 1 : 0;
    chk({tag, "_idle_stall"}, Stall_o, 1);
    chk({tag, "_idle_fault"}, Fault_o, 0);
    chk({tag, "_idle_req"}, Bus_Req_o, 0);
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      if (Stall_o) sc++;
      chk({tag, "_req"}, Bus_Req_o, 1);
      chk({tag, "_addr"}, Bus_Addr_o, e_addr);
      chk({tag, "_be"}, Bus_Be_o, e_be);
      chk({tag, "_we"}, Bus_We_o, wr);
      chk({tag, "_wdata"}, Bus_Wdata_o, e_wd);
      if (i == waits) begin Bus_Ack_i = 1'b1; Bus_Rdata_i = rdata; end
    end
    @(negedge clk);
    Bus_Ack_i = 1'b0; Bus_Rdata_i = '0;
    #1;
    chk({tag, "_done_stall"}, Stall_o, 0);
    chk({tag, "_done_req"}, Bus_Req_o, 0);
    chk({tag, "_rdata"}, Read_Data_o, e_rd);
    chk({tag, "_stall_cycles"}, sc, waits + 2);
  endtask
  task automatic flt(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] e_rd);
    @(negedge clk);
    Mem_Read_i = rd; Mem_Write_i = wr; Funct3_i = f3; Address_i = addr; Write_Data_i = 32'h5A5A5A5A;
    #1;
    chk({tag, "_fault"}, Fault_o, 1);
    chk({tag, "_stall"}, Stall_o, 0);
    chk({tag, "_req"}, Bus_Req_o, 0);
    @(negedge clk);
    chk({tag, "_req_after"}, Bus_Req_o, 0);
    Mem_Read_i = 1'b0; Mem_Write_i = 1'b0;
    #1;
    chk({tag, "_fault_off"}, Fault_o, 0);
    chk({tag, "_rdata"}, Read_Data_o, e_rd);
  endtask
  initial begin
    #2;
    chk("rst_rdata", Read_Data_o, 0);
    chk("rst_stall", Stall_o, 0);
    chk("rst_fault", Fault_o, 0);
    chk("rst_req", Bus_Req_o, 0);
    chk("rst_addr", Bus_Addr_o, 0);
    chk("rst_be", Bus_Be_o, 0);
    chk("rst_wdata", Bus_Wdata_o, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    op("lw", 1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 32'h100, 4'b1111, 0, 32'hDEADBEEF);
    op("lb", 1, 0, 3'b000, 32'h103, 0, 32'h80FF0000, 0, 32'h100, 4'b1000, 0, 32'hFFFFFF80);
    op("lbu", 1, 0, 3'b100, 32'h103, 0, 32'h80FF0000, 0, 32'h100, 4'b1000, 0, 32'h00000080);
    op("lh", 1, 0, 3'b001, 32'h102, 0, 32'h80FF0000, 0, 32'h100, 4'b1100, 0, 32'hFFFF80FF);
    op("lhu", 1, 0, 3'b101, 32'h102, 0, 32'h80FF0000, 0, 32'h100, 4'b1100, 0, 32'h000080FF);
    op("sb", 0, 1, 3'b000, 32'h201, 32'h123456AB, 32'h55555555, 0, 32'h200, 4'b0010, 32'hABABABAB, 32'h000080FF);
    op("sh", 0, 1, 3'b001, 32'h202, 32'h0000BEEF, 32'h55555555, 0, 32'h200, 4'b1100, 32'hBEEFBEEF, 32'h000080FF);
    op("sw", 0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h55555555, 0, 32'h300, 4'b1111, 32'hCAFEF00D, 32'h000080FF);
    flt("lw_mis", 1, 0, 3'b010, 32'h102, 32'h000080FF);
    flt("rd_wr", 1, 1, 3'b010, 32'h100, 32'h000080FF);
    flt("f3_011", 1, 0, 3'b011, 32'h100, 32'h000080FF);
    flt("sh_mis", 0, 1, 3'b001, 32'h201, 32'h000080FF);
    flt("sbu", 0, 1, 3'b100, 32'h200, 32'h000080FF);
    @(negedge clk);
    Bus_Ack_i = 1'b1; Bus_Rdata_i = 32'h99999999;
    @(negedge clk);
    Bus_Ack_i = 1'b0; Bus_Rdata_i = '0;
    chk("idle_ack_rdata", Read_Data_o, 32'h000080FF);
    chk("idle_ack_req", Bus_Req_o, 0);
    op("lw_wait", 1, 0, 3'b010, 32'h10, 0, 32'h11223344, 3, 32'h10, 4'b1111, 0, 32'h11223344);
    op("lw_b2b", 1, 0, 3'b010, 32'h14, 0, 32'h55667788, 0, 32'h14, 4'b1111, 0, 32'h55667788);
    @(negedge clk);
    Mem_Read_i = 1'b1; Mem_Write_i = 1'b0; Funct3_i = 3'b010; Address_i = 32'h400;
    @(negedge clk);
    chk("rstmid_req_bus", Bus_Req_o, 1);
    #2 reset = 1'b0;
    #1;
    chk("rstmid_req", Bus_Req_o, 0);
    chk("rstmid_stall", Stall_o, 0);
    chk("rstmid_rdata", Read_Data_o, 0);
    @(negedge clk);
    Mem_Read_i = 1'b0;
    reset = 1'b1;
    Bus_Ack_i = 1'b1; Bus_Rdata_i = 32'h12345678;
    @(negedge clk);
    Bus_Ack_i = 1'b0; Bus_Rdata_i = '0;
    chk("rstmid_ack_rdata", Read_Data_o, 0);
    chk("rstmid_ack_req", Bus_Req_o, 0);
    chk("rstmid_ack_stall", Stall_o, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_memory_interface.md
# data_memory_interface

Load/store unit between the ALU and data memory. It takes the ALU result as the effective address and the register-file rs2 value as store data. It runs one word-aligned bus transaction per load/store with a request/acknowledge handshake. It stalls the single-cycle core until the access completes and returns byte/half/word load data, sign- or zero-extended, for write-back.

## Interface
- No parameters; data and address widths are fixed at 32.
- clk  in  1  core clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- Mem_Read_i  in  1  current instruction is a load; level, held while Stall_o=1.
- Mem_Write_i  in  1  current instruction is a store; level, held while Stall_o=1.
- Funct3_i  in  3  size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- Address_i  in  32  effective address, the ALU result.
- Write_Data_i  in  32  store data, rs2.
- Read_Data_o  out  32  extended load data, registered.
- Stall_o  out  1  freeze PC and register write-back.
- Fault_o  out  1  one-cycle pulse: misaligned or illegal access; no bus activity.
- Bus_Req_o  out  1  bus request.
- Bus_We_o  out  1  1 = write.
- Bus_Addr_o  out  32  word address, with bits [1:0] = 00.
- Bus_Be_o  out  4  byte enables.
- Bus_Wdata_o  out  32  lane-replicated store data.
- Bus_Rdata_i  in  32  read data, valid with Bus_Ack_i.
- Bus_Ack_i  in  1  transaction complete, one-cycle pulse.

## Operation
- Reset values: state IDLE; all outputs 0, including Read_Data_o.
- FSM states: IDLE, BUS, DONE.
- A request is legal when it meets all of the following:
  - exactly one of Mem_Read_i and Mem_Write_i is 1;
  - Funct3_i is in {000, 001, 010, 100, 101} for loads, or in {000, 001, 010} for stores;
  - halfwords have Address_i[0]=0;
  - words have Address_i[1:0]=00.
- IDLE, legal request:
  - Stall_o=1, combinational, in the same cycle.
  - Latch word address, We, Be, Wdata, Funct3 and Address_i[1:0].
  - Go to BUS.
- IDLE, illegal request (any Mem_* set but request not legal):
  - Fault_o=1 for that cycle; Stall_o=0; stay in IDLE.
  - Read_Data_o is unchanged.
- BUS:
  - Bus_Req_o=1 and Stall_o=1.
  - All Bus_* outputs stay stable until Bus_Ack_i.
  - On Bus_Ack_i, go to DONE. For a load, also register the extracted data into Read_Data_o.
- DONE:
  - Stall_o=0 and Bus_Req_o=0. The core retires the instruction at this edge.
  - Mem_* inputs are ignored, since they still belong to the retiring instruction.
  - Return to IDLE.
- Byte enables:
  - b: 0001 << a[1:0].
  - h: 0011 << a[1:0], where a[1:0] is 00 or 10.
  - w: 1111.
- Write data:
  - b: {4{rs2[7:0]}}.
  - h: {2{rs2[15:0]}}.
  - w: rs2.
- Read extraction:
  - Shift Bus_Rdata_i right by 8*a[1:0].
  - b/h: sign-extend bit 7/15. bu/hu: zero-extend.
- Read_Data_o holds its value until the next completed load. A store does not change it.
- Bus_Ack_i in IDLE or DONE is ignored.

## Timing
- A legal access with ack in the first BUS cycle takes 3 cycles: IDLE (Stall=1), BUS (ack), DONE (Stall=0).
- Each extra wait cycle without ack adds one cycle. There is no timeout.
- Read_Data_o is valid from the DONE cycle onward.
- Fault_o is combinational in the IDLE cycle. The faulting instruction does not stall.
- Reset mid-operation: Bus_Req_o, Stall_o and Read_Data_o drop to 0 asynchronously and the state returns to IDLE. A pending ack is discarded.
- Back-to-back accesses: the next request is accepted in the IDLE cycle right after DONE.

## Test plan
- **Load word:** reset release; lw at addr 0x100; Bus_Rdata_i=0xDEADBEEF with ack on the first BUS cycle -> Bus_Addr_o=0x100, Be=1111, Stall high for 2 cycles, Read_Data_o=0xDEADBEEF in DONE.
- **Signed/unsigned byte loads:** lb at addr 0x103 with Rdata=0x80FF0000 -> Read_Data_o=0xFFFFFF80. lbu, same setup -> 0x00000080. lhu at 0x102 -> 0x000080FF.
- **Stores:**
  - sb at 0x201, rs2=0x123456AB -> Bus_We_o=1, Addr=0x200, Be=0010, Wdata=0xABABABAB. Read_Data_o unchanged.
  - sh at 0x202, rs2=0x0000BEEF -> Be=1100, Wdata=0xBEEFBEEF.
- **Faults:**
  - lw at 0x102 -> Fault_o pulse, Stall_o=0, Bus_Req_o never 1.
  - Mem_Read_i=Mem_Write_i=1 -> Fault_o.
  - Funct3=011 -> Fault_o.
- **Wait states and back-to-back:** ack delayed 4 cycles -> Stall_o high for 5 cycles and Bus_* stable throughout. A second lw presented right after DONE is accepted with no idle gap.
- **Reset mid-access:** assert reset in BUS, between edges -> Bus_Req_o and Stall_o go to 0 immediately. An ack arriving after release produces no Read_Data_o update.
